// File: rtl/tx_delay_pulser.sv
// Transmit focusing delay plus bipolar pulse generator for one beamformer channel.
// A LUT holds one delay per focal zone; each fire waits, pulses, damps and reports done.
module tx_delay_pulser #(
  parameter int ADDR_WD = 7,
  parameter int DLY_WD  = 12,
  parameter int HALF_WD = 6,
  parameter int CYC_WD  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_WD-1:0] lut_addr,
  input  logic [DLY_WD-1:0]  lut_din,
  input  logic               lut_we,
  input  logic [ADDR_WD-1:0] zone_sel,
  input  logic [HALF_WD-1:0] half_period,
  input  logic [CYC_WD-1:0]  num_cycles,
  input  logic               fire,
  input  logic               abort,
  output logic               tx_en,
  output logic               pulse_p,
  output logic               pulse_n,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DELAY,
    S_PULSE,
    S_DAMP,
    S_FIN
  } state_t;

  state_t state_q, state_d;

  logic [DLY_WD-1:0]  lut_mem [2**ADDR_WD];
  logic [DLY_WD-1:0]  rd_data_q, rd_data_d;
  logic [DLY_WD-1:0]  dly_cnt_q, dly_cnt_d;
  logic [DLY_WD-1:0]  dly_val;
  logic [ADDR_WD-1:0] zone_q, zone_d;
  logic [HALF_WD-1:0] half_q, half_d;
  logic [HALF_WD-1:0] half_cnt_q, half_cnt_d;
  logic [HALF_WD-1:0] heff_m1;
  logic [CYC_WD-1:0]  ncyc_q, ncyc_d;
  logic [CYC_WD-1:0]  cyc_cnt_q, cyc_cnt_d;
  logic               phase_q, phase_d;
  logic               tx_en_q, tx_en_d;
  logic               pulse_p_q, pulse_p_d;
  logic               pulse_n_q, pulse_n_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // LUT contents survive reset; writes are accepted in every state.
  always_ff @(posedge clk) begin
    if (lut_we) begin
      lut_mem[lut_addr] <= lut_din;
    end
  end

  // Write-first on the LOAD edge: a same-zone write lands directly in D.
  assign dly_val = (lut_we && (lut_addr == zone_q)) ? lut_din : rd_data_q;
  assign heff_m1 = (half_q == '0) ? '0 : half_q - 1'b1;

  always_comb begin
    state_d    = state_q;
    zone_d     = zone_q;
    half_d     = half_q;
    ncyc_d     = ncyc_q;
    rd_data_d  = rd_data_q;
    dly_cnt_d  = dly_cnt_q;
    half_cnt_d = half_cnt_q;
    cyc_cnt_d  = cyc_cnt_q;
    phase_d    = phase_q;

    unique case (state_q)
      S_IDLE: begin
        if (fire && !abort) begin
          state_d   = S_LOAD;
          zone_d    = zone_sel;
          half_d    = half_period;
          ncyc_d    = num_cycles;
          rd_data_d = (lut_we && (lut_addr == zone_sel)) ? lut_din : lut_mem[zone_sel];
        end
      end
      S_LOAD: begin
        if (dly_val != '0) begin
          state_d   = S_DELAY;
          dly_cnt_d = dly_val - 1'b1;
        end else begin
          state_d    = (ncyc_q != '0) ? S_PULSE : S_DAMP;
          half_cnt_d = heff_m1;
          phase_d    = 1'b0;
          cyc_cnt_d  = ncyc_q - 1'b1;
        end
      end
      S_DELAY: begin
        if (dly_cnt_q == '0) begin
          state_d    = (ncyc_q != '0) ? S_PULSE : S_DAMP;
          half_cnt_d = heff_m1;
          phase_d    = 1'b0;
          cyc_cnt_d  = ncyc_q - 1'b1;
        end else begin
          dly_cnt_d = dly_cnt_q - 1'b1;
        end
      end
      S_PULSE: begin
        // phase 0 drives the positive half, phase 1 the negative half.
        if (half_cnt_q != '0) begin
          half_cnt_d = half_cnt_q - 1'b1;
        end else if (!phase_q) begin
          phase_d    = 1'b1;
          half_cnt_d = heff_m1;
        end else if (cyc_cnt_q == '0) begin
          state_d    = S_DAMP;
          phase_d    = 1'b0;
          half_cnt_d = heff_m1;
        end else begin
          cyc_cnt_d  = cyc_cnt_q - 1'b1;
          phase_d    = 1'b0;
          half_cnt_d = heff_m1;
        end
      end
      S_DAMP: begin
        if (half_cnt_q == '0) begin
          state_d = S_FIN;
        end else begin
          half_cnt_d = half_cnt_q - 1'b1;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end

    // Outputs are registered images of the next state so they change on the state edge.
    tx_en_d   = (state_d == S_LOAD) || (state_d == S_DELAY) ||
                (state_d == S_PULSE) || (state_d == S_DAMP);
    pulse_p_d = (state_d == S_PULSE) && !phase_d;
    pulse_n_d = (state_d == S_PULSE) && phase_d;
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_FIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      zone_q     <= '0;
      half_q     <= '0;
      ncyc_q     <= '0;
      rd_data_q  <= '0;
      dly_cnt_q  <= '0;
      half_cnt_q <= '0;
      cyc_cnt_q  <= '0;
      phase_q    <= 1'b0;
      tx_en_q    <= 1'b0;
      pulse_p_q  <= 1'b0;
      pulse_n_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      zone_q     <= zone_d;
      half_q     <= half_d;
      ncyc_q     <= ncyc_d;
      rd_data_q  <= rd_data_d;
      dly_cnt_q  <= dly_cnt_d;
      half_cnt_q <= half_cnt_d;
      cyc_cnt_q  <= cyc_cnt_d;
      phase_q    <= phase_d;
      tx_en_q    <= tx_en_d;
      pulse_p_q  <= pulse_p_d;
      pulse_n_q  <= pulse_n_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign tx_en   = tx_en_q;
  assign pulse_p = pulse_p_q;
  assign pulse_n = pulse_n_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
